// File: rtl/rfarb_pkg.sv
// Shared types, sizes and field helpers for the register-file write arbiter.
package rfarb_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // Data field i of a flattened requester bus (zero-extended to MAX_REQ fields).
  function automatic logic [XLEN-1:0] field_data(input logic [MAX_REQ*XLEN-1:0] vec,
                                                 input int unsigned i);
    return XLEN'(vec >> (i * XLEN));
  endfunction

  // Address field i of a flattened requester bus (zero-extended to MAX_REQ fields).
  function automatic logic [REG_AW-1:0] field_addr(input logic [MAX_REQ*REG_AW-1:0] vec,
                                                   input int unsigned i);
    return REG_AW'(vec >> (i * REG_AW));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int unsigned  pos;
  logic         found;
  logic [N-1:0] one_pos;

  // First requester after the last winner gets the grant.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    one_pos = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      one_pos = N'(1) << pos;
      if (!found && ((req & one_pos) != '0)) begin
        found = 1'b1;
        gnt   = one_pos;
        idx   = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write sequencer: clears x0..x31 after reset, then round-robins
// the single write port among NREQ writeback requesters. Writes to x0 are
// accepted but suppressed. Optional read bypass under RFARB_BYPASS_EN.
module regfile_wr_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                     clk_Regs,
  input  logic                     rst,
  input  logic                     wr_hold,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0]     req_data,
  output logic                     Reg_Write,
  output logic [REG_AW-1:0]        W_Addr,
  output logic [XLEN-1:0]          W_Data,
  output logic                     init_done
`ifdef RFARB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]        rd_addr_a,
  input  logic [REG_AW-1:0]        rd_addr_b,
  input  logic [XLEN-1:0]          rf_data_a,
  input  logic [XLEN-1:0]          rf_data_b,
  output logic [XLEN-1:0]          fwd_data_a,
  output logic [XLEN-1:0]          fwd_data_b
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                   state_q, state_d;
  logic [REG_AW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     reg_write_d;
  logic [REG_AW-1:0]        w_addr_d;
  logic [XLEN-1:0]          w_data_d;
  logic                     init_done_d;

  logic [NREQ-1:0]          cand;
  logic [NREQ-1:0]          gnt;
  logic [PW-1:0]            gnt_idx;
  logic [MAX_REQ*REG_AW-1:0] addr_ext;
  logic [MAX_REQ*XLEN-1:0]   data_ext;
  logic [REG_AW-1:0]        sel_addr;
  logic [XLEN-1:0]          sel_data;

  // Only RUN with no hold may offer candidates to the arbiter.
  assign cand = ((state_q == ST_RUN) && !wr_hold) ? req_valid : '0;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Grant is combinational so a requester sees ready in the transfer cycle.
  assign req_ready = gnt;

  assign addr_ext = (MAX_REQ*REG_AW)'(req_addr);
  assign data_ext = (MAX_REQ*XLEN)'(req_data);
  assign sel_addr = field_addr(addr_ext, 32'(gnt_idx));
  assign sel_data = field_data(data_ext, 32'(gnt_idx));

  // Next-state and next-output selection for the clear sequence and arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    reg_write_d = 1'b0;
    w_addr_d    = W_Addr;
    w_data_d    = W_Data;
    init_done_d = init_done;
    case (state_q)
      ST_INIT: begin
        reg_write_d = 1'b1;
        w_addr_d    = cnt_q;
        w_data_d    = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == REG_AW'(NREGS - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (gnt != '0) begin
          rr_ptr_d    = gnt_idx;
          w_addr_d    = sel_addr;
          w_data_d    = sel_data;
          reg_write_d = (sel_addr != '0);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rr_ptr_q  <= PW'(NREQ - 1);
      Reg_Write <= 1'b0;
      W_Addr    <= '0;
      W_Data    <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      Reg_Write <= reg_write_d;
      W_Addr    <= w_addr_d;
      W_Data    <= w_data_d;
      init_done <= init_done_d;
    end
  end

`ifdef RFARB_BYPASS_EN
  // Forward the in-flight write to the read ports.
  assign fwd_data_a = (Reg_Write && (W_Addr == rd_addr_a)) ? W_Data : rf_data_a;
  assign fwd_data_b = (Reg_Write && (W_Addr == rd_addr_b)) ? W_Data : rf_data_b;
`endif

endmodule
